// File: rtl/eq_spi_bank.sv
// SPI slave (mode 0, oversampled in the clk domain) with a bank of per-band equalizer gain registers.
// Frames carry an 8-bit header {rw, addr[6:0]} followed by GAIN_W data bits, MSB first.
module eq_spi_bank #(
    parameter int NUM_CH = 8,
    parameter int GAIN_W = 16,
    parameter logic [GAIN_W-1:0] RESET_GAIN = GAIN_W'(16'h4000)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     sck,
    input  logic                     sdi,
    input  logic                     ce,
    output logic                     sdo,
    output logic [NUM_CH*GAIN_W-1:0] gains,
    output logic                     wr_valid,
    output logic [6:0]               wr_addr,
    output logic                     frame_err,
    output logic                     done
);

    localparam int FRAME_W = 8 + GAIN_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    // The shift register must hold at least the 7 header bits below rw.
    localparam int SH_W    = (GAIN_W > 7) ? GAIN_W : 7;

    localparam logic [CNT_W-1:0] CNT_LAST_HDR  = CNT_W'(7);
    localparam logic [CNT_W-1:0] CNT_LAST_DATA = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] CNT_FULL      = CNT_W'(FRAME_W);

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        DATA,
        DRAIN
    } state_t;

    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n;

    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_n = rst_sync_q[1];

    logic [2:0] sck_sync_q, sck_sync_d;
    logic [2:0] ce_sync_q, ce_sync_d;
    logic [1:0] sdi_sync_q, sdi_sync_d;

    always_comb begin
        sck_sync_d = {sck_sync_q[1:0], sck};
        ce_sync_d  = {ce_sync_q[1:0], ce};
        sdi_sync_d = {sdi_sync_q[0], sdi};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q <= '0;
            ce_sync_q  <= '0;
            sdi_sync_q <= '0;
        end else begin
            sck_sync_q <= sck_sync_d;
            ce_sync_q  <= ce_sync_d;
            sdi_sync_q <= sdi_sync_d;
        end
    end

    logic sck_rise, sck_fall, ce_rise, ce_fall, sdi_s;

    assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
    assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
    assign ce_rise  = ce_sync_q[1] & ~ce_sync_q[2];
    assign ce_fall  = ~ce_sync_q[1] & ce_sync_q[2];
    assign sdi_s    = sdi_sync_q[1];

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SH_W-1:0]     shift_q, shift_d;
    logic                rw_q, rw_d;
    logic [6:0]          addr_q, addr_d;
    logic                overrun_q, overrun_d;
    logic [GAIN_W-1:0]   sdo_shift_q, sdo_shift_d;
    logic [GAIN_W-1:0]   gains_q [NUM_CH];
    logic [GAIN_W-1:0]   gains_d [NUM_CH];
    logic                wr_valid_q, wr_valid_d;
    logic                frame_err_q, frame_err_d;
    logic [6:0]          wr_addr_q, wr_addr_d;

    logic [6:0]          hdr_addr;
    logic [GAIN_W-1:0]   rd_word;
    logic                addr_ok;
    logic                frame_ok;

    assign hdr_addr = {shift_q[5:0], sdi_s};
    assign addr_ok  = int'(addr_q) < NUM_CH;
    assign frame_ok = (cnt_q == CNT_FULL) && !overrun_q && addr_ok;

    // Out-of-range reads return zero rather than aliasing onto a real channel.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (hdr_addr == 7'(k)) begin
                rd_word = gains_q[k];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        overrun_d   = overrun_q;
        sdo_shift_d = sdo_shift_q;
        gains_d     = gains_q;
        wr_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        wr_addr_d   = wr_addr_q;

        if (ce_fall) begin
            state_d = IDLE;
            if (state_q != IDLE) begin
                if (!frame_ok) begin
                    frame_err_d = 1'b1;
                end else if (!rw_q) begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (addr_q == 7'(k)) begin
                            gains_d[k] = shift_q[GAIN_W-1:0];
                        end
                    end
                    wr_valid_d = 1'b1;
                    wr_addr_d  = addr_q;
                end
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (ce_rise) begin
                        state_d   = HEADER;
                        cnt_d     = '0;
                        shift_d   = '0;
                        overrun_d = 1'b0;
                    end
                end
                HEADER: begin
                    if (sck_rise) begin
                        shift_d = {shift_q[SH_W-2:0], sdi_s};
                        cnt_d   = cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST_HDR) begin
                            rw_d        = shift_q[6];
                            addr_d      = hdr_addr;
                            sdo_shift_d = shift_q[6] ? rd_word : '0;
                            state_d     = DATA;
                        end
                    end
                end
                DATA: begin
                    if (sck_rise) begin
                        shift_d = {shift_q[SH_W-2:0], sdi_s};
                        cnt_d   = cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST_DATA) begin
                            state_d = DRAIN;
                        end
                    end else if (sck_fall && rw_q) begin
                        sdo_shift_d = {sdo_shift_q[GAIN_W-2:0], 1'b0};
                    end
                end
                DRAIN: begin
                    if (sck_rise) begin
                        overrun_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            overrun_q   <= 1'b0;
            sdo_shift_q <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                gains_q[k] <= RESET_GAIN;
            end
            wr_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            overrun_q   <= overrun_d;
            sdo_shift_q <= sdo_shift_d;
            gains_q     <= gains_d;
            wr_valid_q  <= wr_valid_d;
            frame_err_q <= frame_err_d;
            wr_addr_q   <= wr_addr_d;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_gain_out
            assign gains[g*GAIN_W +: GAIN_W] = gains_q[g];
        end
    endgenerate

    assign sdo       = (state_q == DATA) && rw_q && sdo_shift_q[GAIN_W-1];
    assign wr_valid  = wr_valid_q;
    assign frame_err = frame_err_q;
    assign wr_addr   = wr_addr_q;
    assign done      = ~ce_sync_q[1];

endmodule

// File: tb/tb_eq_spi_bank.sv
// Directed bench for eq_spi_bank: bit-bangs SPI frames and checks the gain bank, pulses and readback.
// Expected values are hand-computed from the frame contents.
module tb_eq_spi_bank;

    localparam int NUM_CH = 8;
    localparam int GAIN_W = 16;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic                     sck = 1'b0;
    logic                     sdi = 1'b0;
    logic                     ce = 1'b0;
    logic                     sdo;
    logic [NUM_CH*GAIN_W-1:0] gains;
    logic                     wr_valid;
    logic [6:0]               wr_addr;
    logic                     frame_err;
    logic                     done;

    int check_count = 0;
    int error_count = 0;
    int wr_pulses = 0;
    int err_pulses = 0;

    logic [15:0] read_bits;
    logic        drain_sdo;

    eq_spi_bank #(
        .NUM_CH(NUM_CH),
        .GAIN_W(GAIN_W),
        .RESET_GAIN(16'h4000)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .sck(sck),
        .sdi(sdi),
        .ce(ce),
        .sdo(sdo),
        .gains(gains),
        .wr_valid(wr_valid),
        .wr_addr(wr_addr),
        .frame_err(frame_err),
        .done(done)
    );

    always #5 clk = ~clk;

    // Pulse widths are counted in clk cycles, so a one-cycle pulse counts as exactly 1.
    always @(negedge clk) begin
        if (wr_valid) wr_pulses++;
        if (frame_err) err_pulses++;
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", check_count, error_count + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] gainOf(input int k);
        return gains[k*GAIN_W +: GAIN_W];
    endfunction

    // Sends hdr then n_data bits of data (MSB first, zero-padded past 16).
    // sdo is captured during the high phase of bits 7..22 and once more at bit 23.
    // A non-negative abort_at pulls reset_n low just before that bit.
    task automatic applyStimulus(input logic [7:0] hdr, input int n_data, input logic [15:0] data,
                                 input int abort_at, output logic [15:0] rd, output logic drain);
        int  total;
        bit  aborted;
        logic b;
        rd = '0;
        drain = 1'b0;
        aborted = 1'b0;
        wr_pulses = 0;
        err_pulses = 0;
        total = 8 + n_data;
        ce = 1'b1;
        waitClk(8);
        for (int i = 0; i < total; i++) begin
            if (i == abort_at) begin
                aborted = 1'b1;
                break;
            end
            if (i < 8) b = hdr[7-i];
            else if (i - 8 < 16) b = data[15-(i-8)];
            else b = 1'b0;
            sdi = b;
            waitClk(8);
            sck = 1'b1;
            waitClk(6);
            if (i >= 7 && i < 23) rd = {rd[14:0], sdo};
            if (i == 23) drain = sdo;
            waitClk(2);
            sck = 1'b0;
        end
        if (aborted) begin
            reset_n = 1'b0;
            waitClk(2);
            ce = 1'b0;
            sck = 1'b0;
            sdi = 1'b0;
            waitClk(4);
            reset_n = 1'b1;
            waitClk(8);
        end else begin
            waitClk(8);
            ce = 1'b0;
            waitClk(10);
        end
    endtask

    initial begin
        $display("[TB] eq_spi_bank directed test start");
        reset_n = 1'b0;
        waitClk(4);
        reset_n = 1'b1;
        waitClk(6);

        for (int k = 0; k < NUM_CH; k++) begin
            checkOutput($sformatf("reset_gain%0d", k), 32'(gainOf(k)), 32'h4000);
        end
        checkOutput("reset_done", 32'(done), 32'd1);
        checkOutput("reset_sdo", 32'(sdo), 32'd0);
        checkOutput("reset_wr_valid", 32'(wr_valid), 32'd0);
        checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
        checkOutput("reset_wr_addr", 32'(wr_addr), 32'd0);

        // Zero-bit frame: ce pulse without any sck
        wr_pulses = 0;
        err_pulses = 0;
        ce = 1'b1;
        waitClk(8);
        checkOutput("busy_done", 32'(done), 32'd0);
        ce = 1'b0;
        waitClk(10);
        checkOutput("zero_bit_err", 32'(err_pulses), 32'd1);
        checkOutput("zero_bit_done", 32'(done), 32'd1);

        applyStimulus(8'h03, 16, 16'hBEEF, -1, read_bits, drain_sdo);
        checkOutput("write_wr_pulses", 32'(wr_pulses), 32'd1);
        checkOutput("write_err_pulses", 32'(err_pulses), 32'd0);
        checkOutput("write_wr_addr", 32'(wr_addr), 32'd3);
        checkOutput("write_gain3", 32'(gainOf(3)), 32'hBEEF);
        for (int k = 0; k < NUM_CH; k++) begin
            if (k != 3) checkOutput($sformatf("write_other%0d", k), 32'(gainOf(k)), 32'h4000);
        end

        applyStimulus(8'h83, 16, 16'h0000, -1, read_bits, drain_sdo);
        checkOutput("read_bits", 32'(read_bits), 32'hBEEF);
        checkOutput("read_drain_sdo", 32'(drain_sdo), 32'd0);
        checkOutput("read_wr_pulses", 32'(wr_pulses), 32'd0);
        checkOutput("read_err_pulses", 32'(err_pulses), 32'd0);
        checkOutput("read_idle_sdo", 32'(sdo), 32'd0);
        checkOutput("read_gain3", 32'(gainOf(3)), 32'hBEEF);

        applyStimulus(8'h05, 10, 16'h1234, -1, read_bits, drain_sdo);
        checkOutput("short_err_pulses", 32'(err_pulses), 32'd1);
        checkOutput("short_wr_pulses", 32'(wr_pulses), 32'd0);
        checkOutput("short_gain5", 32'(gainOf(5)), 32'h4000);

        applyStimulus(8'h05, 17, 16'h1234, -1, read_bits, drain_sdo);
        checkOutput("overrun_err_pulses", 32'(err_pulses), 32'd1);
        checkOutput("overrun_wr_pulses", 32'(wr_pulses), 32'd0);
        checkOutput("overrun_gain5", 32'(gainOf(5)), 32'h4000);

        applyStimulus(8'h09, 16, 16'h5555, -1, read_bits, drain_sdo);
        checkOutput("badaddr_err_pulses", 32'(err_pulses), 32'd1);
        checkOutput("badaddr_wr_pulses", 32'(wr_pulses), 32'd0);
        checkOutput("badaddr_wr_addr", 32'(wr_addr), 32'd3);

        applyStimulus(8'h89, 16, 16'h0000, -1, read_bits, drain_sdo);
        checkOutput("badread_err_pulses", 32'(err_pulses), 32'd1);
        checkOutput("badread_bits", 32'(read_bits), 32'h0000);

        applyStimulus(8'h07, 16, 16'h0001, -1, read_bits, drain_sdo);
        checkOutput("ch7_gain7", 32'(gainOf(7)), 32'h0001);
        checkOutput("ch7_gain6", 32'(gainOf(6)), 32'h4000);
        checkOutput("ch7_wr_addr", 32'(wr_addr), 32'd7);

        applyStimulus(8'h02, 16, 16'hA5A5, 12, read_bits, drain_sdo);
        checkOutput("abort_gain2", 32'(gainOf(2)), 32'h4000);
        checkOutput("abort_gain3", 32'(gainOf(3)), 32'h4000);
        checkOutput("abort_wr_pulses", 32'(wr_pulses), 32'd0);
        checkOutput("abort_err_pulses", 32'(err_pulses), 32'd0);
        checkOutput("abort_wr_addr", 32'(wr_addr), 32'd0);

        applyStimulus(8'h02, 16, 16'hA5A5, -1, read_bits, drain_sdo);
        checkOutput("after_abort_wr_pulses", 32'(wr_pulses), 32'd1);
        checkOutput("after_abort_gain2", 32'(gainOf(2)), 32'hA5A5);
        checkOutput("after_abort_wr_addr", 32'(wr_addr), 32'd2);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
